carcontrol_memory_arbiter: RTL and testbench

Two-master arbiter sharing the single-port 32-bit on-chip program/data RAM (25600 words, 15-bit word address, byte enables, unregistered output) of the carControl system. Sits between two Avalon-MM style masters (e.g. CPU data port and a DMA/telemetry engine) and the RAM's single port. Applies round-robin arbitration, serializes accesses through a small FSM, and returns read data with a fixed latency.

---
 rtl/carcontrol_memory_arbiter_if.sv | 52 +++++
 rtl/carcontrol_memory_arbiter.sv | 127 ++++++++++++
 tb/tb_carcontrol_memory_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/carcontrol_memory_arbiter_if.sv
// Bus bundle between the two Avalon-MM style masters, the arbiter and the shared RAM port.
// The master modport is the environment side (masters plus RAM); the slave modport is the arbiter.
interface carcontrol_memory_arbiter_if #(
  parameter int unsigned ADDR_W = 15
);
  logic [ADDR_W-1:0] m0_address;
  logic [3:0]        m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [31:0]       m0_writedata;
  logic              m0_waitrequest;
  logic [31:0]       m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [3:0]        m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [31:0]       m1_writedata;
  logic              m1_waitrequest;
  logic [31:0]       m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;
  logic              err_oob;

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata,
    input  err_oob
  );

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata,
    output err_oob
  );
endinterface

// File: rtl/carcontrol_memory_arbiter.sv
// Round-robin two-master arbiter for the single-port carControl RAM (IDLE/ISSUE/CAPTURE FSM).
// Optional out-of-range guard enabled by defining CARCONTROL_MEM_ARB_RANGE_CHECK_EN.
module carcontrol_memory_arbiter #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DEPTH  = 25600
) (
  input  logic clk,
  input  logic reset,
  carcontrol_memory_arbiter_if.slave bus
);

  if (DEPTH > (32'd1 << ADDR_W)) begin : g_depth_check
    $error("DEPTH exceeds the word address space");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t            state;
  logic              last_grant;
  logic              gnt;
  logic              op_write;
  logic              oob;
  logic              err;

  logic              req0;
  logic              req1;
  logic              gnt_c;
  logic              accept;
  logic              sel_oob;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;
  logic              sel_write;
  logic [31:0]       cap_data;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;

  // On a tie the master that was not granted last wins; otherwise the lone requester wins.
  assign gnt_c  = (req0 & req1) ? ~last_grant : req1;
  assign accept = ~reset & (state == IDLE) & (req0 | req1);

  assign bus.m0_waitrequest = ~(accept & ~gnt_c);
  assign bus.m1_waitrequest = ~(accept &  gnt_c);
  assign bus.mem_clken      = ~reset;
  assign bus.err_oob        = err;

  always_comb begin
    sel_addr  = bus.m0_address;
    sel_be    = bus.m0_byteenable;
    sel_wdata = bus.m0_writedata;
    sel_write = bus.m0_write;
    if (gnt_c) begin
      sel_addr  = bus.m1_address;
      sel_be    = bus.m1_byteenable;
      sel_wdata = bus.m1_writedata;
      sel_write = bus.m1_write;
    end
  end

`ifdef CARCONTROL_MEM_ARB_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  assign sel_oob  = ({1'b0, sel_addr} >= DEPTH_L);
  assign cap_data = oob ? 32'h0000_0000 : bus.mem_readdata;
`else
  assign sel_oob  = 1'b0;
  assign cap_data = bus.mem_readdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      last_grant           <= 1'b1;
      gnt                  <= 1'b0;
      op_write             <= 1'b0;
      oob                  <= 1'b0;
      err                  <= 1'b0;
      bus.mem_address      <= '0;
      bus.mem_byteenable   <= '0;
      bus.mem_writedata    <= '0;
      bus.mem_chipselect   <= 1'b0;
      bus.mem_write        <= 1'b0;
      bus.m0_readdata      <= '0;
      bus.m1_readdata      <= '0;
      bus.m0_readdatavalid <= 1'b0;
      bus.m1_readdatavalid <= 1'b0;
    end else begin
      bus.m0_readdatavalid <= 1'b0;
      bus.m1_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            gnt                <= gnt_c;
            last_grant         <= gnt_c;
            op_write           <= sel_write;
            oob                <= sel_oob;
            err                <= err | sel_oob;
            bus.mem_address    <= sel_addr;
            bus.mem_byteenable <= sel_be;
            bus.mem_writedata  <= sel_wdata;
            bus.mem_chipselect <= ~sel_oob;
            bus.mem_write      <= sel_write;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_chipselect <= 1'b0;
          bus.mem_write      <= 1'b0;
          state              <= op_write ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          // RAM output is combinational, so it is valid now; route only to the owner.
          if (gnt) begin
            bus.m1_readdata      <= cap_data;
            bus.m1_readdatavalid <= 1'b1;
          end else begin
            bus.m0_readdata      <= cap_data;
            bus.m0_readdatavalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carcontrol_memory_arbiter.sv
// Randomized self-checking bench for carcontrol_memory_arbiter with a RAM model and a shadow-memory reference.
module tb_carcontrol_memory_arbiter;

`ifdef CARCONTROL_MEM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam int unsigned DEPTH = 25600;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cycle = 0;
  int   cs_count = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  carcontrol_memory_arbiter_if #(.ADDR_W(15)) bus ();

  carcontrol_memory_arbiter #(.ADDR_W(15), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] init_pat(input logic [14:0] a);
    return {16'hDEAD, 1'b0, a};
  endfunction

  // RAM: unregistered read, byte-lane write on the clock edge.
  logic [31:0] ram [0:32767];
  bit filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 32768; i++) ram[i] <= init_pat(15'(i));
      filled <= 1'b1;
    end else if (bus.mem_clken && bus.mem_chipselect && bus.mem_write) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_byteenable[b]) ram[bus.mem_address][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
    end
  end
  assign bus.mem_readdata = ram[bus.mem_address];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (bus.mem_chipselect === 1'b1) cs_count <= cs_count + 1;
  end

  // Reference: what each word should hold after all accepted writes.
  logic [31:0] shadow [int];

  function automatic logic [31:0] model_read(input logic [14:0] a);
    if (RC && int'(a) >= int'(DEPTH)) return 32'h0;
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_pat(a);
  endfunction

  function automatic void model_write(input logic [14:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] cur;
    cur = model_read(a);
    for (int b = 0; b < 4; b++) if (be[b]) cur[b*8 +: 8] = d[b*8 +: 8];
    shadow[int'(a)] = cur;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int m, input logic rd, input logic wr, input logic [14:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    if (m == 0) begin
      bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
      bus.m0_byteenable = be; bus.m0_writedata = wd;
    end else begin
      bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
      bus.m1_byteenable = be; bus.m1_writedata = wd;
    end
  endtask

  function automatic logic wait_of(input int m);
    return (m == 0) ? bus.m0_waitrequest : bus.m1_waitrequest;
  endfunction
  function automatic logic valid_of(input int m);
    return (m == 0) ? bus.m0_readdatavalid : bus.m1_readdatavalid;
  endfunction
  function automatic logic [31:0] data_of(input int m);
    return (m == 0) ? bus.m0_readdata : bus.m1_readdata;
  endfunction

  // One command from master m; read latency is counted from the accept cycle.
  task automatic access(input int m, input bit wr, input logic [14:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat, output bit ok);
    bit acc;
    acc = 1'b0; rd = '0; lat = 0; ok = 1'b0;
    set_cmd(m, !wr, wr, a, be, wd);
    for (int t = 0; t < 20 && !acc; t++) begin
      #1;
      if (wait_of(m) == 1'b0) acc = 1'b1;
      step();
    end
    set_cmd(m, 1'b0, 1'b0, '0, '0, '0);
    if (!acc) return;
    if (wr) begin ok = 1'b1; return; end
    for (int k = 1; k <= 10; k++) begin
      if (valid_of(m)) begin rd = data_of(m); lat = k; ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_cmd(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0);
    set_cmd(1, 1'b0, 1'b1, 15'h0020, 4'hF, 32'h1234_5678);
    step(); step();
    #1;
    n_checks++;
    if ({bus.m0_waitrequest, bus.m1_waitrequest} !== 2'b11) begin
      n_fail++; $display("FAIL reset_waitrequest: got %b expected 11", {bus.m0_waitrequest, bus.m1_waitrequest});
    end
    n_checks++;
    if ({bus.m0_readdatavalid, bus.m1_readdatavalid, bus.mem_chipselect, bus.mem_write, bus.mem_clken, bus.err_oob} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 000000",
        {bus.m0_readdatavalid, bus.m1_readdatavalid, bus.mem_chipselect, bus.mem_write, bus.mem_clken, bus.err_oob});
    end
    n_checks++;
    if ({bus.m0_readdata, bus.m1_readdata, bus.mem_writedata} !== 96'h0 || bus.mem_address !== 15'h0 || bus.mem_byteenable !== 4'h0) begin
      n_fail++; $display("FAIL reset_data: rd0=%h rd1=%h wd=%h addr=%h be=%h expected all zero",
        bus.m0_readdata, bus.m1_readdata, bus.mem_writedata, bus.mem_address, bus.mem_byteenable);
    end
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    reset = 1'b0;
    step();
    n_checks++;
    if (bus.mem_clken !== 1'b1) begin
      n_fail++; $display("FAIL clken_after_reset: got %b expected 1", bus.mem_clken);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; int lat; bit ok;
    access(0, 1'b1, 15'h0010, 4'hF, 32'hCAFE_BABE, rd, lat, ok);
    model_write(15'h0010, 4'hF, 32'hCAFE_BABE);
    n_checks++;
    if (!ok || bus.mem_chipselect !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_address !== 15'h0010 ||
        bus.mem_writedata !== 32'hCAFE_BABE || bus.mem_byteenable !== 4'hF) begin
      n_fail++; $display("FAIL write_issue: ok=%0d cs=%b we=%b addr=%h wd=%h be=%h expected 1 1 1 0010 cafebabe f",
        ok, bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_writedata, bus.mem_byteenable);
    end
    access(0, 1'b0, 15'h0010, 4'hF, 32'h0, rd, lat, ok);
    n_checks++;
    if (!ok || lat != 3) begin
      n_fail++; $display("FAIL read_latency: ok=%0d got %0d expected 3", ok, lat);
    end
    n_checks++;
    if (rd !== model_read(15'h0010)) begin
      n_fail++; $display("FAIL read_data: got %h expected %h", rd, model_read(15'h0010));
    end
  endtask

  task automatic test_byteenable();
    logic [31:0] rd; int lat; bit ok;
    logic [14:0] a; logic [3:0] be; logic [31:0] d; int m;
    access(1, 1'b1, 15'h0030, 4'hF, 32'h1122_3344, rd, lat, ok);
    model_write(15'h0030, 4'hF, 32'h1122_3344);
    access(1, 1'b1, 15'h0030, 4'h2, 32'h0000_AA00, rd, lat, ok);
    model_write(15'h0030, 4'h2, 32'h0000_AA00);
    access(0, 1'b0, 15'h0030, 4'hF, 32'h0, rd, lat, ok);
    n_checks++;
    if (!ok || rd !== 32'h1122_AA44 || rd !== model_read(15'h0030)) begin
      n_fail++; $display("FAIL byteenable_merge: got %h expected %h", rd, model_read(15'h0030));
    end
    for (int i = 0; i < 6; i++) begin
      a  = 15'($urandom_range(0, 63));
      be = 4'($urandom_range(1, 15));
      d  = $urandom;
      m  = int'($urandom_range(0, 1));
      access(m, 1'b1, a, be, d, rd, lat, ok);
      model_write(a, be, d);
      access(1 - m, 1'b0, a, 4'hF, 32'h0, rd, lat, ok);
      n_checks++;
      if (!ok || lat != 3 || rd !== model_read(a)) begin
        n_fail++; $display("FAIL random_rmw[%0d]: addr=%h ok=%0d lat=%0d got %h expected %h", i, a, ok, lat, rd, model_read(a));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] q0[$]; logic [31:0] q1[$];
    logic [31:0] prev0, prev1, exp;
    logic [14:0] a0, a1;
    int gexp, ngr, nv0, nv1, acc_m;
    logic w0, w1;
    do_reset();
    a0 = 15'($urandom_range(0, 63));
    a1 = 15'($urandom_range(0, 63));
    set_cmd(0, 1'b1, 1'b0, a0, 4'hF, 32'h0);
    set_cmd(1, 1'b1, 1'b0, a1, 4'hF, 32'h0);
    gexp = 0; ngr = 0; nv0 = 0; nv1 = 0;
    prev0 = bus.m0_readdata; prev1 = bus.m1_readdata;
    for (int c = 0; c < 40; c++) begin
      #1;
      w0 = bus.m0_waitrequest; w1 = bus.m1_waitrequest;
      acc_m = -1;
      if (!w0 || !w1) begin
        acc_m = w0 ? 1 : 0;
        n_checks++;
        if (w0 == w1 || acc_m != gexp) begin
          n_fail++; $display("FAIL rr_grant[%0d]: waitrequest m0=%b m1=%b expected grant to m%0d", ngr, w0, w1, gexp);
        end
        if (acc_m == 0) q0.push_back(model_read(a0)); else q1.push_back(model_read(a1));
        gexp = 1 - gexp;
        ngr++;
      end
      step();
      if (bus.m0_readdatavalid === 1'b1) begin
        nv0++;
        exp = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (bus.m0_readdata !== exp || bus.m1_readdata !== prev1) begin
          n_fail++; $display("FAIL rr_route_m0: rd0=%h expected %h, rd1=%h expected held %h", bus.m0_readdata, exp, bus.m1_readdata, prev1);
        end
      end
      if (bus.m1_readdatavalid === 1'b1) begin
        nv1++;
        exp = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (bus.m1_readdata !== exp || bus.m0_readdata !== prev0) begin
          n_fail++; $display("FAIL rr_route_m1: rd1=%h expected %h, rd0=%h expected held %h", bus.m1_readdata, exp, bus.m0_readdata, prev0);
        end
      end
      prev0 = bus.m0_readdata; prev1 = bus.m1_readdata;
      if (acc_m >= 0) begin
        if (ngr >= 8) begin
          set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
          set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        end else if (acc_m == 0) begin
          a0 = 15'($urandom_range(0, 63)); set_cmd(0, 1'b1, 1'b0, a0, 4'hF, 32'h0);
        end else begin
          a1 = 15'($urandom_range(0, 63)); set_cmd(1, 1'b1, 1'b0, a1, 4'hF, 32'h0);
        end
      end
    end
    n_checks++;
    if (ngr != 8 || nv0 != 4 || nv1 != 4) begin
      n_fail++; $display("FAIL rr_counts: grants=%0d v0=%0d v1=%0d expected 8 4 4", ngr, nv0, nv1);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] addrs[4]; logic [31:0] data[4]; int acc_cyc[4];
    logic [31:0] rd; int lat; bit ok; int i; bit acc;
    for (int k = 0; k < 4; k++) begin
      addrs[k] = 15'(32'h200 + 32'(k) * 8 + $urandom_range(0, 7));
      data[k]  = $urandom;
    end
    i = 0;
    set_cmd(1, 1'b0, 1'b1, addrs[0], 4'hF, data[0]);
    for (int t = 0; t < 30 && i < 4; t++) begin
      #1;
      n_checks++;
      if (bus.m0_waitrequest !== 1'b1) begin
        n_fail++; $display("FAIL b2b_m0_wait: got %b expected 1", bus.m0_waitrequest);
      end
      acc = (bus.m1_waitrequest == 1'b0);
      step();
      n_checks++;
      if (bus.m0_readdatavalid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_m0_valid: got %b expected 0", bus.m0_readdatavalid);
      end
      if (acc) begin
        acc_cyc[i] = cycle;
        model_write(addrs[i], 4'hF, data[i]);
        i++;
        if (i < 4) set_cmd(1, 1'b0, 1'b1, addrs[i], 4'hF, data[i]);
        else set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
      end
    end
    n_checks++;
    if (i != 4) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d expected 4", i);
      set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    end else begin
      for (int k = 1; k < 4; k++) begin
        n_checks++;
        if (acc_cyc[k] - acc_cyc[k-1] != 2) begin
          n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 2", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      access(0, 1'b0, addrs[k], 4'hF, 32'h0, rd, lat, ok);
      n_checks++;
      if (!ok || rd !== model_read(addrs[k])) begin
        n_fail++; $display("FAIL b2b_readback[%0d]: got %h expected %h", k, rd, model_read(addrs[k]));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    step(); step(); step();
    acc = 1'b0;
    set_cmd(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'h0);
    for (int t = 0; t < 10 && !acc; t++) begin
      #1;
      if (bus.m0_waitrequest == 1'b0) acc = 1'b1;
      step();
    end
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    n_checks++;
    if (!acc) begin
      n_fail++; $display("FAIL midreset_accept: got no accept expected one");
    end
    step();
    reset = 1'b1;
    set_cmd(1, 1'b1, 1'b0, 15'h0011, 4'hF, 32'h0);
    step();
    n_checks++;
    if ({bus.m0_readdatavalid, bus.m1_readdatavalid, bus.mem_chipselect, bus.mem_write, bus.mem_clken, bus.err_oob} !== 6'b0 ||
        {bus.m0_waitrequest, bus.m1_waitrequest} !== 2'b11) begin
      n_fail++; $display("FAIL midreset_ctrl: v0 v1 cs we clken err=%b wait=%b expected 000000 11",
        {bus.m0_readdatavalid, bus.m1_readdatavalid, bus.mem_chipselect, bus.mem_write, bus.mem_clken, bus.err_oob},
        {bus.m0_waitrequest, bus.m1_waitrequest});
    end
    n_checks++;
    if (bus.m0_readdata !== 32'h0 || bus.mem_address !== 15'h0 || bus.mem_byteenable !== 4'h0 || bus.mem_writedata !== 32'h0) begin
      n_fail++; $display("FAIL midreset_data: rd0=%h addr=%h be=%h wd=%h expected zeros",
        bus.m0_readdata, bus.mem_address, bus.mem_byteenable, bus.mem_writedata);
    end
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (bus.m0_readdatavalid !== 1'b0) begin
        n_fail++; $display("FAIL midreset_no_valid[%0d]: got %b expected 0", k, bus.m0_readdatavalid);
      end
    end
  endtask

  task automatic test_oob();
    logic [31:0] rd; int lat; bit ok; int c0;
    c0 = cs_count;
    access(0, 1'b0, 15'(DEPTH), 4'hF, 32'h0, rd, lat, ok);
    n_checks++;
    if (!ok || lat != 3 || rd !== model_read(15'(DEPTH))) begin
      n_fail++; $display("FAIL oob_read: ok=%0d lat=%0d got %h expected %h", ok, lat, rd, model_read(15'(DEPTH)));
    end
    n_checks++;
    if (cs_count - c0 != (RC ? 0 : 1)) begin
      n_fail++; $display("FAIL oob_chipselect: got %0d cycles expected %0d", cs_count - c0, RC ? 0 : 1);
    end
    n_checks++;
    if (bus.err_oob !== RC) begin
      n_fail++; $display("FAIL oob_err_set: got %b expected %b", bus.err_oob, RC);
    end
    access(1, 1'b0, 15'h0010, 4'hF, 32'h0, rd, lat, ok);
    n_checks++;
    if (!ok || rd !== model_read(15'h0010) || bus.err_oob !== RC) begin
      n_fail++; $display("FAIL oob_sticky: rd=%h expected %h err=%b expected %b", rd, model_read(15'h0010), bus.err_oob, RC);
    end
    do_reset();
    step();
    n_checks++;
    if (bus.err_oob !== 1'b0) begin
      n_fail++; $display("FAIL oob_err_clear: got %b expected 0", bus.err_oob);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byteenable();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_oob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
